// File: rtl/gpio_walk_pkg.sv
// Shared types and widths for the GPIO walking-one pattern source.
//   walk_state_t : FSM state encoding (IDLE, GAP, WALK, DONE)
//   HOLD_W       : width of the per-step hold counter
//   PASS_W       : width of the completed-pass counter
package gpio_walk_pkg;

  localparam int unsigned HOLD_W = 24;
  localparam int unsigned PASS_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    WALK,
    DONE
  } walk_state_t;

endpackage

// File: rtl/walk_hold_timer.sv
// Loadable down-counter that times how long each pattern step is held.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset (count -> 0)
//   load     : load count with load_val (step entry)
//   clear    : force count to 0 (takes priority over load)
//   load_val : reload value, i.e. hold length minus one
//   expired  : count has reached 0; the current step ends at the next edge
module walk_hold_timer
  import gpio_walk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [HOLD_W-1:0] load_val,
  output logic              expired
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/gpio_walk_gen.sv
// Walking-one pattern source for the user GPIO outputs: an all-zero gap, then
// bit 0 .. bit WIDTH-1 one-hot in turn, each step held for a fixed number of
// clocks so a slow chip-level monitor can see every step.
// Optional feature: define GPIO_WALK_HOLD_LOAD_EN to take the hold length from
// hold_i (latched at the start of each pass, 0 treated as 1) instead of
// HOLD_CYCLES.
// Ports:
//   wb_clk_i   : clock
//   wb_rst_i   : asynchronous active-high reset
//   en_i       : run enable (level); low returns to IDLE at the next edge
//   hold_i     : runtime hold length (only with GPIO_WALK_HOLD_LOAD_EN)
//   io_out     : registered pattern, always zero or one-hot
//   io_oeb     : pad output enable (active low), driven after reset release
//   busy_o     : high while in GAP or WALK
//   pass_cnt_o : completed full walks since the last start, saturating
module gpio_walk_gen
  import gpio_walk_pkg::*;
#(
  parameter int unsigned WIDTH       = 34,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned NUM_PASSES  = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic [WIDTH-1:0]  io_out,
  output logic [WIDTH-1:0]  io_oeb,
  output logic              busy_o,
  output logic [PASS_W-1:0] pass_cnt_o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);
  localparam logic [HOLD_W-1:0] HoldReload = HOLD_W'(HOLD_CYCLES - 1);

  walk_state_t       state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [PASS_W-1:0] pass_q, pass_d, pass_inc;
  logic              tmr_load, tmr_clear, tmr_expired, gap_entry;
  logic [HOLD_W-1:0] tmr_load_val;

`ifdef GPIO_WALK_HOLD_LOAD_EN
  // Reload value for the current pass; refreshed from hold_i on every gap entry.
  logic [HOLD_W-1:0] hold_len_q;
  logic [HOLD_W-1:0] hold_in_m1;

  assign hold_in_m1   = (hold_i == '0) ? '0 : hold_i - HOLD_W'(1);
  // The gap itself already runs with the newly latched length.
  assign tmr_load_val = gap_entry ? hold_in_m1 : hold_len_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_len_q <= HoldReload;
    end else if (gap_entry) begin
      hold_len_q <= hold_in_m1;
    end
  end
`else
  logic unused_hold;

  assign unused_hold  = ^hold_i;
  assign tmr_load_val = HoldReload;
`endif

  walk_hold_timer u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  assign pass_inc = (pass_q == '1) ? pass_q : pass_q + PASS_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    gap_entry = 1'b0;
    if (!en_i) begin
      state_d   = IDLE;
      idx_d     = '0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = GAP;
          idx_d     = '0;
          pass_d    = '0;
          tmr_load  = 1'b1;
          gap_entry = 1'b1;
        end
        GAP: begin
          if (tmr_expired) begin
            state_d  = WALK;
            idx_d    = '0;
            tmr_load = 1'b1;
          end
        end
        WALK: begin
          if (tmr_expired) begin
            if (idx_q == LastIdx) begin
              pass_d = pass_inc;
              idx_d  = '0;
              if (NUM_PASSES != 0 && 32'(pass_inc) == NUM_PASSES) begin
                state_d = DONE;
              end else begin
                state_d   = GAP;
                tmr_load  = 1'b1;
                gap_entry = 1'b1;
              end
            end else begin
              idx_d    = idx_q + IdxW'(1);
              tmr_load = 1'b1;
            end
          end
        end
        DONE: begin
          // Held here until en_i drops.
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pass_q     <= '0;
      io_out     <= '0;
      io_oeb     <= '1;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      // Outputs are decoded from next state so they change on the same edge.
      io_out     <= (state_d == WALK) ? (WIDTH'(1) << idx_d) : '0;
      io_oeb     <= '0;
      busy_o     <= (state_d == GAP) || (state_d == WALK);
    end
  end

  assign pass_cnt_o = pass_q;

endmodule

// File: tb/tb_gpio_walk_gen.sv
// Self-checking bench for gpio_walk_gen. Two instances: dut_a (HOLD_CYCLES=4,
// NUM_PASSES=2) and dut_b (HOLD_CYCLES=1, NUM_PASSES=0). A behavioural model
// tracks time within the current pass and derives the pattern arithmetically.
module tb_gpio_walk_gen;

  localparam int W = 34;

  typedef struct packed {
    int st;    // 0 idle, 1 running (gap or walk), 2 done
    int t;     // clocks since the current pass started
    int pass;  // completed passes
    int h;     // hold length in force for the current pass
  } mdl_t;

  logic          clk;
  logic          rst;
  logic          en_a, en_b;
  logic [23:0]   hold_a, hold_b;
  logic [W-1:0]  io_a, oeb_a, io_b, oeb_b;
  logic          busy_a, busy_b;
  logic [7:0]    pass_a, pass_b;

  mdl_t ma, mb;
  logic oeb_ones;
  int   total, bad;

  gpio_walk_gen #(
    .WIDTH       (W),
    .HOLD_CYCLES (4),
    .NUM_PASSES  (2)
  ) dut_a (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en_i       (en_a),
    .hold_i     (hold_a),
    .io_out     (io_a),
    .io_oeb     (oeb_a),
    .busy_o     (busy_a),
    .pass_cnt_o (pass_a)
  );

  gpio_walk_gen #(
    .WIDTH       (W),
    .HOLD_CYCLES (1),
    .NUM_PASSES  (0)
  ) dut_b (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en_i       (en_b),
    .hold_i     (hold_b),
    .io_out     (io_b),
    .io_oeb     (oeb_b),
    .busy_o     (busy_b),
    .pass_cnt_o (pass_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour.
  function automatic mdl_t mdl_next(mdl_t m, logic en, int hin, int nump);
    mdl_t n;
    n = m;
    if (!en) begin
      n.st = 0;
      n.t  = 0;
      return n;
    end
    case (m.st)
      0: begin
        n.st   = 1;
        n.t    = 0;
        n.pass = 0;
        n.h    = hin;
      end
      1: begin
        n.t = m.t + 1;
        if (n.t == (W + 1) * m.h) begin
          n.pass = (m.pass < 255) ? m.pass + 1 : 255;
          if (nump != 0 && n.pass == nump) begin
            n.st = 2;
          end else begin
            n.t = 0;
            n.h = hin;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  // Step 0 of a pass is the gap; step k>0 is bit k-1.
  function automatic logic [W-1:0] exp_io(mdl_t m);
    logic [W-1:0] one;
    int step;
    one = 1;
    if (m.st != 1) return '0;
    step = m.t / m.h;
    if (step == 0) return '0;
    return one << (step - 1);
  endfunction

  task automatic compare_all();
    check_eq("io_a", 64'(io_a), 64'(exp_io(ma)));
    check_eq("oeb_a", 64'(oeb_a), oeb_ones ? 64'(W'('1)) : 64'd0);
    check_eq("busy_a", 64'(busy_a), 64'(ma.st == 1));
    check_eq("pass_a", 64'(pass_a), 64'(ma.pass));
    check_eq("onehot_a", 64'($onehot0(io_a)), 64'd1);
    check_eq("io_b", 64'(io_b), 64'(exp_io(mb)));
    check_eq("oeb_b", 64'(oeb_b), oeb_ones ? 64'(W'('1)) : 64'd0);
    check_eq("busy_b", 64'(busy_b), 64'(mb.st == 1));
    check_eq("pass_b", 64'(pass_b), 64'(mb.pass));
    check_eq("onehot_b", 64'($onehot0(io_b)), 64'd1);
  endtask

  task automatic tick();
    int ha, hb;
    @(posedge clk);
`ifdef GPIO_WALK_HOLD_LOAD_EN
    ha = (hold_a == 0) ? 1 : int'(hold_a);
    hb = (hold_b == 0) ? 1 : int'(hold_b);
`else
    ha = 4;
    hb = 1;
`endif
    if (rst) begin
      ma       = '0;
      mb       = '0;
      oeb_ones = 1'b1;
    end else begin
      ma       = mdl_next(ma, en_a, ha, 2);
      mb       = mdl_next(mb, en_b, hb, 0);
      oeb_ones = 1'b0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    logic found;
    total    = 0;
    bad      = 0;
    ma       = '0;
    mb       = '0;
    oeb_ones = 1'b1;
    rst      = 1'b1;
    en_a     = 1'b0;
    en_b     = 1'b0;
    hold_a   = 24'd4;
    hold_b   = 24'd1;

    // Reset values, then io_oeb released at the first edge after reset.
    #2;
    compare_all();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Two full passes then DONE.
    en_a  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ma.st == 2) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t1_done_reached", 64'(found), 64'd1);
    check_eq("t1_done_pass", 64'(pass_a), 64'd2);
    check_eq("t1_done_busy", 64'(busy_a), 64'd0);
    check_eq("t1_done_io", 64'(io_a), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    en_a = 1'b0;
    tick();

    // Drop en_i at bit 10, then restart from a fresh gap.
    en_a  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_io(ma) == 34'h400) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t3_reach_bit10", 64'(found), 64'd1);
    en_a = 1'b0;
    tick();
    check_eq("t3_drop_io", 64'(io_a), 64'd0);
    check_eq("t3_drop_busy", 64'(busy_a), 64'd0);
    en_a  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_io(ma) != '0) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t3_restart_found", 64'(found), 64'd1);
    check_eq("t3_restart_bit0", 64'(io_a), 64'd1);

    // Asynchronous reset mid-walk at bit 8.
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_io(ma) == 34'h100) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t2_reach_bit8", 64'(found), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("t2_async_io", 64'(io_a), 64'd0);
    check_eq("t2_async_busy", 64'(busy_a), 64'd0);
    check_eq("t2_async_oeb", 64'(oeb_a), 64'(W'('1)));
    check_eq("t2_async_pass", 64'(pass_a), 64'd0);
    ma       = '0;
    mb       = '0;
    oeb_ones = 1'b1;
    en_a     = 1'b0;
    #1 rst = 1'b0;
    tick();
    check_eq("t2_oeb_after", 64'(oeb_a), 64'd0);

    // Randomized enable segments and hold_i changes.
    for (int seg = 0; seg < 12; seg++) begin
      int len;
      len  = int'($urandom_range(20, 400));
      en_a = 1'b1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 49) == 0) hold_a = 24'($urandom_range(0, 6));
        tick();
      end
      en_a = 1'b0;
      len  = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) tick();
    end

    // Continuous walk with 1-clock steps until the pass counter saturates.
    en_a = 1'b0;
    en_b = 1'b1;
    for (int i = 0; i < 9100; i++) tick();
    check_eq("t4_sat_255", 64'(pass_b), 64'd255);
    en_b = 1'b0;
    tick();
    check_eq("t4_retain_255", 64'(pass_b), 64'd255);

`ifdef GPIO_WALK_HOLD_LOAD_EN
    // Runtime hold: 3, then 6 mid-pass (next pass only), then 0 treated as 1.
    hold_a = 24'd3;
    en_a   = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    hold_a = 24'd6;
    for (int i = 0; i < 300; i++) tick();
    en_a = 1'b0;
    tick();
    hold_a = 24'd0;
    en_a   = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    en_a = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
